// File: rtl/code_programmer.sv
`default_nettype none
//============================================================================
// Module      : code_programmer
// Description : Keypad-driven code change controller. Verifies the stored
//               code, takes the new code twice, commits it on a match and
//               locks out further attempts after repeated failures.
// Revision    : 1.0 - initial release
//============================================================================
module code_programmer #(
    parameter logic [2:0] DEFAULT_CODE = 3'b000,
    parameter int         TIMEOUT      = 200,
    parameter int         MAX_FAIL     = 3,
    parameter int         LOCKOUT      = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] codein,
    input  logic       enter,
    input  logic       prog_req,
    output logic [2:0] coderetrive,
    output logic       busy,
    output logic       prog_ok,
    output logic       prog_fail,
    output logic       locked
);

    // One shared counter times both the entry timeout and the lockout period
    localparam int c_cnt_lim = (TIMEOUT > LOCKOUT) ? TIMEOUT : LOCKOUT;
    localparam int c_cnt_w   = $clog2(c_cnt_lim + 1);
    localparam int c_fail_w  = $clog2(MAX_FAIL + 1);

    localparam logic [c_cnt_w-1:0]  c_cnt_one      = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_sat      = {c_cnt_w{1'b1}};
    localparam logic [c_cnt_w-1:0]  c_timeout_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0]  c_lockout_last = c_cnt_w'(LOCKOUT - 1);
    localparam logic [c_fail_w-1:0] c_fail_one     = c_fail_w'(1);
    localparam logic [c_fail_w-1:0] c_fail_lim     = c_fail_w'(MAX_FAIL);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        OLD  = 3'd1,
        NEW1 = 3'd2,
        NEW2 = 3'd3,
        LOCK = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_fail_w-1:0]   r_fail_cnt;
    logic [c_fail_w-1:0]   w_fail_inc;
    logic [2:0]            r_code;
    logic [2:0]            r_temp;
    logic                  r_prog_ok;
    logic                  r_prog_fail;
    logic                  w_in_seq;
    logic                  w_timeout;
    logic                  w_cnt_clr;
    logic                  w_capture;
    logic                  w_commit;
    logic                  w_fail;
    logic                  w_fail_clr;

    assign w_in_seq   = (r_state == OLD) || (r_state == NEW1) || (r_state == NEW2);
    assign w_timeout  = (r_cnt >= c_timeout_last);
    assign w_fail_inc = (r_fail_cnt >= c_fail_lim) ? c_fail_lim : (r_fail_cnt + c_fail_one);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a same-cycle enter always beats timeout expiry
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
        w_fail      = 1'b0;
        w_fail_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (prog_req && !enter) begin
                    w_state_nxt = OLD;
                    w_cnt_clr   = 1'b1;
                end
            end
            OLD: begin
                if (enter) begin
                    if (codein == r_code) begin
                        w_state_nxt = NEW1;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_fail = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_fail = 1'b1;
                end
            end
            NEW1: begin
                if (enter) begin
                    w_state_nxt = NEW2;
                    w_capture   = 1'b1;
                    w_cnt_clr   = 1'b1;
                end else if (w_timeout) begin
                    w_fail = 1'b1;
                end
            end
            NEW2: begin
                if (enter) begin
                    if (codein == r_temp) begin
                        w_state_nxt = IDLE;
                        w_commit    = 1'b1;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_fail = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_fail = 1'b1;
                end
            end
            LOCK: begin
                if (r_cnt >= c_lockout_last) begin
                    w_state_nxt = IDLE;
                    w_cnt_clr   = 1'b1;
                    w_fail_clr  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_clr   = 1'b1;
            end
        endcase
        // Any failure leaves the sequence; the counter restarts for a lockout
        if (w_fail) begin
            w_state_nxt = (w_fail_inc >= c_fail_lim) ? LOCK : IDLE;
            w_cnt_clr   = 1'b1;
        end
    end

    // Saturating timeout / lockout counter, idle outside active states
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if ((w_in_seq || (r_state == LOCK)) && (r_cnt != c_cnt_sat)) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    // Consecutive-failure counter, cleared only by a commit or lockout expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail_cnt <= '0;
        end else if (w_commit || w_fail_clr) begin
            r_fail_cnt <= '0;
        end else if (w_fail) begin
            r_fail_cnt <= w_fail_inc;
        end
    end

    // Holding register for the first entry of the new code
    always_ff @(posedge clk) begin
        if (rst) begin
            r_temp <= 3'b000;
        end else if (w_capture) begin
            r_temp <= codein;
        end else if (w_commit || w_fail) begin
            r_temp <= 3'b000;
        end
    end

    // Stored code; only a confirmed commit may change it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_code <= DEFAULT_CODE;
        end else if (w_commit) begin
            r_code <= r_temp;
        end
    end

    // Result pulses, one cycle after the deciding edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prog_ok   <= 1'b0;
            r_prog_fail <= 1'b0;
        end else begin
            r_prog_ok   <= w_commit;
            r_prog_fail <= w_fail;
        end
    end

    assign coderetrive = r_code;
    assign busy        = w_in_seq;
    assign locked      = (r_state == LOCK);
    assign prog_ok     = r_prog_ok;
    assign prog_fail   = r_prog_fail;

endmodule
`default_nettype wire

// File: tb/tb_code_programmer.sv
`default_nettype none
//============================================================================
// Module      : tb_code_programmer
// Description : Self-checking bench for code_programmer. Expected outcome
//               pulses are queued as stimulus is driven and compared with
//               the pulses observed on the outputs.
// Revision    : 1.0 - initial release
//============================================================================
module tb_code_programmer;

    localparam logic [1:0] c_ev_ok   = 2'd1;
    localparam logic [1:0] c_ev_fail = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] codein;
    logic       enter;
    logic       prog_req;
    logic [2:0] coderetrive;
    logic       busy;
    logic       prog_ok;
    logic       prog_fail;
    logic       locked;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] exp_code;
    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];

    code_programmer #(
        .DEFAULT_CODE(3'b000),
        .TIMEOUT     (200),
        .MAX_FAIL    (3),
        .LOCKOUT     (1000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .codein     (codein),
        .enter      (enter),
        .prog_req   (prog_req),
        .coderetrive(coderetrive),
        .busy       (busy),
        .prog_ok    (prog_ok),
        .prog_fail  (prog_fail),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    // Record every outcome pulse seen, one entry per high cycle
    always @(negedge clk) begin
        if (prog_ok === 1'b1)   obs_q.push_back(c_ev_ok);
        if (prog_fail === 1'b1) obs_q.push_back(c_ev_fail);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic request();
        prog_req = 1'b1;
        step(1);
        prog_req = 1'b0;
    endtask

    task automatic press(input logic [2:0] code);
        enter  = 1'b1;
        codein = code;
        step(1);
        enter  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enter = 1'b0; prog_req = 1'b0; codein = 3'b000;
        step(3);
        n_checks++;
        if (coderetrive !== 3'b000 || busy !== 1'b0 || locked !== 1'b0 ||
            prog_ok !== 1'b0 || prog_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got code=%b busy=%b locked=%b ok=%b fail=%b want 000 0 0 0 0",
                     coderetrive, busy, locked, prog_ok, prog_fail);
        end
        rst = 1'b0;
        exp_code = 3'b000;
        step(2);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_program();
        request();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL prog_busy: got %b want 1", busy);
        end
        press(exp_code);
        press(3'b101);
        exp_q.push_back(c_ev_ok);
        press(3'b101);
        exp_code = 3'b101;
        n_checks++;
        if (coderetrive !== exp_code || prog_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL prog_commit: got code=%b ok=%b want %b 1", coderetrive, prog_ok, exp_code);
        end
        step(1);
        n_checks++;
        if (busy !== 1'b0 || prog_ok !== 1'b0) begin
            n_fail++; $display("FAIL prog_after: got busy=%b ok=%b want 0 0", busy, prog_ok);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL prog_events: got %0d pulses want %0d", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end
        while (exp_q.size() > 0) begin
            logic [1:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL prog_event: got %0d want %0d", o, e); end
        end
    endtask

    task automatic test_bad_old();
        request();
        exp_q.push_back(c_ev_fail);
        press(3'b011);
        n_checks++;
        if (prog_fail !== 1'b1 || busy !== 1'b0 || locked !== 1'b0 || coderetrive !== exp_code) begin
            n_fail++;
            $display("FAIL bad_old: got fail=%b busy=%b locked=%b code=%b want 1 0 0 %b",
                     prog_fail, busy, locked, coderetrive, exp_code);
        end
        step(2);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL bad_old_events: got %0d pulses want %0d", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end
        while (exp_q.size() > 0) begin
            logic [1:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL bad_old_event: got %0d want %0d", o, e); end
        end
    endtask

    task automatic test_bad_confirm();
        request();
        press(exp_code);
        press(3'b110);
        exp_q.push_back(c_ev_fail);
        press(3'b111);
        n_checks++;
        if (prog_fail !== 1'b1 || busy !== 1'b0 || coderetrive !== exp_code) begin
            n_fail++;
            $display("FAIL bad_confirm: got fail=%b busy=%b code=%b want 1 0 %b",
                     prog_fail, busy, coderetrive, exp_code);
        end
        step(2);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL confirm_events: got %0d pulses want %0d", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end
        while (exp_q.size() > 0) begin
            logic [1:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL confirm_event: got %0d want %0d", o, e); end
        end
    endtask

    task automatic test_lockout();
        int   n;
        logic saw_busy;
        // Third consecutive failure
        request();
        exp_q.push_back(c_ev_fail);
        press(3'b000);
        n_checks++;
        if (locked !== 1'b1 || prog_fail !== 1'b1) begin
            n_fail++; $display("FAIL lock_enter: got locked=%b fail=%b want 1 1", locked, prog_fail);
        end
        n = 0;
        saw_busy = 1'b0;
        while (locked === 1'b1 && n < 2000) begin
            if (n == 10) prog_req = 1'b1;
            if (n == 20) begin enter = 1'b1; codein = exp_code; end
            step(1);
            prog_req = 1'b0;
            enter    = 1'b0;
            if (busy === 1'b1) saw_busy = 1'b1;
            n++;
        end
        n_checks++;
        if (n != 1000) begin
            n_fail++; $display("FAIL lock_length: got %0d cycles want 1000", n);
        end
        n_checks++;
        if (saw_busy !== 1'b0) begin
            n_fail++; $display("FAIL lock_ignore: got busy=1 during lockout want 0");
        end
        request();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL lock_release: got busy=%b want 1", busy);
        end
        // Fail count restarted, so a single miss must not relock
        exp_q.push_back(c_ev_fail);
        press(3'b000);
        n_checks++;
        if (locked !== 1'b0 || prog_fail !== 1'b1) begin
            n_fail++; $display("FAIL lock_count_clear: got locked=%b fail=%b want 0 1", locked, prog_fail);
        end
        step(2);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL lock_events: got %0d pulses want %0d", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end
        while (exp_q.size() > 0) begin
            logic [1:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL lock_event: got %0d want %0d", o, e); end
        end
    endtask

    task automatic test_timeout();
        // No entry at all: abort after 200 cycles in OLD
        request();
        step(199);
        n_checks++;
        if (busy !== 1'b1 || prog_fail !== 1'b0) begin
            n_fail++; $display("FAIL tmo_early: got busy=%b fail=%b want 1 0", busy, prog_fail);
        end
        exp_q.push_back(c_ev_fail);
        step(1);
        n_checks++;
        if (busy !== 1'b0 || prog_fail !== 1'b1) begin
            n_fail++; $display("FAIL tmo_expire: got busy=%b fail=%b want 0 1", busy, prog_fail);
        end
        step(2);
        // Entry on the last allowed cycle is accepted
        request();
        step(199);
        press(exp_code);
        n_checks++;
        if (busy !== 1'b1 || prog_fail !== 1'b0) begin
            n_fail++; $display("FAIL tmo_last_enter: got busy=%b fail=%b want 1 0", busy, prog_fail);
        end
        press(3'b010);
        exp_q.push_back(c_ev_ok);
        press(3'b010);
        exp_code = 3'b010;
        n_checks++;
        if (coderetrive !== exp_code || prog_ok !== 1'b1) begin
            n_fail++; $display("FAIL tmo_commit: got code=%b ok=%b want %b 1", coderetrive, prog_ok, exp_code);
        end
        step(2);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL tmo_events: got %0d pulses want %0d", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end
        while (exp_q.size() > 0) begin
            logic [1:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL tmo_event: got %0d want %0d", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] codes [2];
        codes[0] = 3'b011;
        codes[1] = 3'b100;
        for (int i = 0; i < 2; i++) begin
            request();
            press(exp_code);
            press(codes[i]);
            exp_q.push_back(c_ev_ok);
            press(codes[i]);
            exp_code = codes[i];
            n_checks++;
            if (coderetrive !== exp_code) begin
                n_fail++; $display("FAIL b2b_code%0d: got %b want %b", i, coderetrive, exp_code);
            end
        end
        step(2);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL b2b_events: got %0d pulses want %0d", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end
        while (exp_q.size() > 0) begin
            logic [1:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_event: got %0d want %0d", o, e); end
        end
    endtask

    task automatic test_ignore();
        // prog_req together with enter in IDLE does not start a sequence
        prog_req = 1'b1;
        enter    = 1'b1;
        codein   = exp_code;
        step(1);
        prog_req = 1'b0;
        enter    = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL ignore_req_enter: got busy=%b want 0", busy);
        end
        step(2);
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL ignore_events: got %0d pulses want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        request();
        press(exp_code);
        press(3'b110);
        // Matching confirmation in the reset cycle: reset must win
        rst    = 1'b1;
        enter  = 1'b1;
        codein = 3'b110;
        step(1);
        rst    = 1'b0;
        enter  = 1'b0;
        exp_code = 3'b000;
        n_checks++;
        if (coderetrive !== exp_code || busy !== 1'b0 || prog_ok !== 1'b0 || prog_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got code=%b busy=%b ok=%b fail=%b want 000 0 0 0",
                     coderetrive, busy, prog_ok, prog_fail);
        end
        step(3);
        n_checks++;
        if (obs_q.size() != 0 || coderetrive !== exp_code) begin
            n_fail++; $display("FAIL reset_mid_after: got %0d pulses code=%b want 0 %b",
                               obs_q.size(), coderetrive, exp_code);
            obs_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_bad_old();
        test_bad_confirm();
        test_lockout();
        test_timeout();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/code_programmer.md
CODE_PROGRAMMER -- requirements
Module: code_programmer

Interface
REQ-001 Parameter DEFAULT_CODE, 3'b000, code loaded into the stored-code register at reset.
REQ-002 Parameter TIMEOUT, 200, idle cycles allowed between entry steps before abort.
REQ-003 Parameter MAX_FAIL, 3, consecutive failed attempts that trigger lockout.
REQ-004 Parameter LOCKOUT, 1000, lockout duration in cycles.
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 codein  input  3  keypad code value, sampled only in cycles where enter=1.
REQ-008 enter  input  1  one-cycle strobe qualifying codein.
REQ-009 prog_req  input  1  one-cycle strobe requesting a code change.
REQ-010 coderetrive  output  3  currently stored code, registered, fed to the lock comparator.
REQ-011 busy  output  1  high while a programming sequence is in progress.
REQ-012 prog_ok  output  1  one-cycle pulse when a new code is committed.
REQ-013 prog_fail  output  1  one-cycle pulse on any failed or aborted sequence.
REQ-014 locked  output  1  high during lockout.

Function
REQ-015 FSM states SHALL be IDLE, OLD, NEW1, NEW2 and LOCK.
REQ-016 IDLE: prog_req=1 with locked=0 -> OLD, timeout counter cleared; enter is ignored in IDLE.
REQ-017 OLD: enter with codein==coderetrive -> NEW1; enter with mismatch -> fail.
REQ-018 NEW1: enter -> capture codein into temp register -> NEW2.
REQ-019 NEW2: enter with codein==temp -> coderetrive<=temp on the same edge, prog_ok pulse in the next cycle, fail counter cleared -> IDLE.
REQ-020 NEW2: enter with codein!=temp -> fail; coderetrive unchanged.
REQ-021 Fail action: prog_fail pulse in the next cycle, fail counter +1, temp discarded.
REQ-022 After a fail, if the fail counter reaches MAX_FAIL -> LOCK; otherwise -> IDLE.
REQ-023 Timeout counter: cleared on every accepted enter and on entry to OLD; increments each cycle in OLD/NEW1/NEW2; at TIMEOUT-1 without enter -> fail.
REQ-024 enter and timeout expiry in the same cycle: enter wins.
REQ-025 prog_req while busy, in LOCK, or in the same cycle as enter in IDLE: prog_req is ignored.
REQ-026 LOCK: locked=1; the counter runs for LOCKOUT cycles, then -> IDLE with locked=0 and the fail counter cleared; all inputs are ignored during LOCK.
REQ-027 busy=1 exactly in OLD, NEW1 and NEW2.
REQ-028 Counter widths: the timeout/lockout counter SHALL be wide enough for max(TIMEOUT, LOCKOUT) and SHALL saturate, never wrap.
REQ-029 The fail counter is cleared only by a successful commit, lockout expiry, or reset.
REQ-030 coderetrive changes only on commit or reset and never glitches within a sequence.

Reset
REQ-031 Synchronous rst=1 SHALL force: state IDLE, coderetrive=DEFAULT_CODE, temp=0, counters=0, busy=0, prog_ok=0, prog_fail=0, locked=0.
REQ-032 rst mid-sequence or mid-lockout SHALL abort with no prog_ok or prog_fail pulse, and the stored code SHALL revert to DEFAULT_CODE.
REQ-033 rst has priority over every other input in the same cycle.

Verification
REQ-034 Reset, then prog_req, then enter codein 000, 101, 101 -> prog_ok pulse once; coderetrive=101; busy low afterwards.
REQ-035 With stored code 101: prog_req, then enter 011 -> prog_fail pulse; coderetrive stays 101; state IDLE.
REQ-036 prog_req, enter old code, enter 110, enter 111 -> prog_fail; coderetrive unchanged.
REQ-037 Three consecutive fails -> locked=1 for 1000 cycles; prog_req ignored during lockout; locked=0 at cycle 1000; the next prog_req is accepted.
REQ-038 prog_req then no enter for 200 cycles -> prog_fail and IDLE; enter on cycle 199 -> accepted, no fail.
REQ-039 rst asserted in NEW2 -> no pulses, coderetrive=000, busy=0 on the next cycle.
